// File: rtl/avmm_shadow_regbank_pkg.sv
// Shared address map, register bit positions and status word layout
// for the shadow/active Avalon-MM register bank.
package avmm_regbank_pkg;

    localparam int unsigned ADDR_SHADOW_BASE = 32'h00;
    localparam int unsigned ADDR_CTRL        = 32'h40;
    localparam int unsigned ADDR_COMMIT      = 32'h41;
    localparam int unsigned ADDR_STATUS      = 32'h42;
    localparam int unsigned ADDR_ACTIVE_BASE = 32'h80;

    localparam int unsigned CTRL_AUTO_COMMIT_BIT = 0;
    localparam int unsigned STATUS_PENDING_BIT   = 0;
    localparam int unsigned STATUS_CNT_LSB       = 8;
    localparam int unsigned STATUS_CNT_W         = 8;

    typedef struct packed {
        logic [15:0]                                         reserved_hi;
        logic [STATUS_CNT_W-1:0]                             commit_cnt;
        logic [STATUS_CNT_LSB-STATUS_PENDING_BIT-2:0]        reserved_lo;
        logic                                                pending;
    } status_t;

endpackage

// File: rtl/avmm_shadow_regbank_if.sv
// Avalon-MM agent bus bundle (no waitrequest, fixed read latency of one).
interface avmm_shadow_regbank_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, write, writedata, byteenable, read,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, write, writedata, byteenable, read,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/avmm_shadow_regbank_rst_pipe_n.sv
// Active-low reset shift pipeline: assertion and release both take
// RST_STAGES edges; flops rely on the device power-up value of 0.
module rst_pipe_n #(
    parameter int unsigned RST_STAGES = 2
) (
    input  logic clk,
    input  logic rst_in,
    output logic rst_n
);
    logic [RST_STAGES-1:0] pipe;

    // Shift form is valid for a single stage as well.
    always_ff @(posedge clk) begin
        pipe <= (pipe << 1) | RST_STAGES'(rst_in);
    end

    assign rst_n = pipe[RST_STAGES-1];
endmodule

// File: rtl/avmm_shadow_regbank.sv
// Avalon-MM register bank with shadow registers that reach the exported
// channels together on a COMMIT write, or per-write in auto-commit mode.
module avmm_shadow_regbank
    import avmm_regbank_pkg::*;
#(
    parameter int unsigned       NUM_CH     = 4,
    parameter int unsigned       DATA_W     = 32,
    parameter int unsigned       ADDR_W     = 8,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0,
    parameter int unsigned       RST_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst_in,
    avmm_shadow_regbank_if.slave     s0,
    output logic [NUM_CH*DATA_W-1:0] r_export,
    output logic                     commit_pulse
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic rst_n;

    rst_pipe_n #(
        .RST_STAGES(RST_STAGES)
    ) u_rst_pipe (
        .clk   (clk),
        .rst_in(rst_in),
        .rst_n (rst_n)
    );

    logic [DATA_W-1:0]       shadow [NUM_CH];
    logic [DATA_W-1:0]       active [NUM_CH];
    logic                    auto_commit;
    logic                    pending;
    logic [STATUS_CNT_W-1:0] commit_cnt;
    logic [DATA_W-1:0]       readdata_q;
    logic                    readdatavalid_q;
    logic                    commit_pulse_q;

    logic [31:0]             addr;
    logic [DATA_W-1:0]       be_mask;
    logic [DATA_W-1:0]       shadow_sel;
    logic [DATA_W-1:0]       shadow_wr_word;
    logic [DATA_W-1:0]       rd_word;
    logic [NUM_CH-1:0]       shadow_hit;
    logic                    wr_shadow;
    logic                    wr_ctrl;
    logic                    wr_commit;
    status_t                 status;

    always_comb begin
        addr = 32'(s0.address);

        be_mask = '0;
        for (int unsigned b = 0; b < BE_W; b++) begin
            be_mask[b*8 +: 8] = {8{s0.byteenable[b]}};
        end

        shadow_hit = '0;
        shadow_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_SHADOW_BASE + i) begin
                shadow_hit[i] = 1'b1;
                shadow_sel    = shadow[i];
            end
        end
        shadow_wr_word = (shadow_sel & ~be_mask) | (s0.writedata & be_mask);

        wr_shadow = s0.write && (|shadow_hit) && (|s0.byteenable);
        wr_ctrl   = s0.write && (addr == ADDR_CTRL);
        wr_commit = s0.write && (addr == ADDR_COMMIT);

        status            = '0;
        status.pending    = pending;
        status.commit_cnt = commit_cnt;

        rd_word = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (addr == ADDR_SHADOW_BASE + i) rd_word = shadow[i];
            if (addr == ADDR_ACTIVE_BASE + i) rd_word = active[i];
        end
        if (addr == ADDR_CTRL)   rd_word = DATA_W'(auto_commit);
        if (addr == ADDR_STATUS) rd_word = DATA_W'(status);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                shadow[i] <= RESET_VAL;
                active[i] <= RESET_VAL;
            end
            auto_commit     <= 1'b0;
            pending         <= 1'b0;
            commit_cnt      <= '0;
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            commit_pulse_q  <= 1'b0;
        end else begin
            commit_pulse_q  <= 1'b0;
            readdatavalid_q <= s0.read;
            // rd_word is taken from pre-edge state, so a same-cycle write is not visible.
            if (s0.read) readdata_q <= rd_word;

            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (wr_shadow && shadow_hit[i]) begin
                    shadow[i] <= shadow_wr_word;
                    if (auto_commit) active[i] <= shadow_wr_word;
                end
            end
            if (wr_shadow && !auto_commit) pending <= 1'b1;

            if (wr_ctrl && s0.byteenable[CTRL_AUTO_COMMIT_BIT/8]) begin
                auto_commit <= s0.writedata[CTRL_AUTO_COMMIT_BIT];
            end

            if (wr_commit) begin
                for (int unsigned i = 0; i < NUM_CH; i++) begin
                    active[i] <= shadow[i];
                end
                pending        <= 1'b0;
                commit_cnt     <= commit_cnt + 1'b1;
                commit_pulse_q <= 1'b1;
            end
        end
    end

    always_comb begin
        r_export = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            r_export[i*DATA_W +: DATA_W] = active[i];
        end
    end

    assign s0.readdata      = readdata_q;
    assign s0.readdatavalid = readdatavalid_q;
    assign commit_pulse     = commit_pulse_q;
endmodule

// File: doc/avmm_shadow_regbank.md
Name: avmm_shadow_regbank

Overview:
- Parametrised Avalon-MM slave register bank driving NUM_CH exported control words.
- Sits between the Platform Designer interconnect and the fabric logic it controls.
- Writes land in shadow registers and reach the outputs together on a COMMIT write, or immediately in auto-commit mode.
- Adds read-back, byte enables, a status/commit counter and a configurable-depth internal reset pipeline.

Parameters:
- NUM_CH, 4, number of exported channels (1..64).
- DATA_W, 32, channel and bus data width (multiple of 8).
- ADDR_W, 8, word address width.
- RESET_VAL, 0, reset value of every shadow and active register (DATA_W bits).
- RST_STAGES, 2, depth of the internal reset pipeline (>=1).

Ports:
- clk  in  1  single clock.
- rst_in  in  1  reset, synchronous, active-low.
- s0_address  in  ADDR_W  word address.
- s0_write  in  1  write strobe.
- s0_writedata  in  DATA_W  write data.
- s0_byteenable  in  DATA_W/8  byte lanes for the write.
- s0_read  in  1  read strobe.
- s0_readdata  out  DATA_W  read data, valid with s0_readdatavalid.
- s0_readdatavalid  out  1  read response strobe.
- r_export  out  NUM_CH*DATA_W  active channels; channel i at [i*DATA_W +: DATA_W].
- commit_pulse  out  1  one-cycle strobe on every commit.

Behaviour:
- Interface (already decided): one clock `clk`; reset `rst_in` is synchronous and active-low.
- Reset pipeline:
  - rst_in shifts through RST_STAGES flops, initialised to 0; the last stage is the internal active-low reset.
  - Reset takes effect RST_STAGES edges after rst_in is sampled low and releases RST_STAGES edges after it is sampled high.
  - At power-up the block is held in reset until the pipeline fills with 1s.
- Reset values:
  - All shadow and active registers = RESET_VAL.
  - CTRL = 0, pending = 0, commit_cnt = 0.
  - s0_readdata = 0, s0_readdatavalid = 0, commit_pulse = 0.
  - Reset asserting mid-operation discards any in-flight read response; s0_readdatavalid is 0 from the first reset cycle.
- Address map (word addresses):
  - 0x00..NUM_CH-1: SHADOW[i], R/W.
  - 0x40: CTRL, R/W; bit0 AUTO_COMMIT, other bits read 0.
  - 0x41: COMMIT, write-only; write data ignored; reads return 0.
  - 0x42: STATUS, RO; bit0 pending, bits[15:8] commit_cnt.
  - 0x80..0x80+NUM_CH-1: ACTIVE[i], RO.
  - Unmapped addresses: writes ignored, reads return 0.
- Writes:
  - Take effect at the sampling edge.
  - Only lanes with byteenable=1 are updated; byteenable=0 means no change.
  - Writes to RO addresses are ignored.
- Shadow write with AUTO_COMMIT=0: updates shadow only and sets pending.
- Shadow write with AUTO_COMMIT=1: updates shadow and the matching ACTIVE on the same edge, so r_export shows it the next cycle. pending is unchanged and no commit_pulse fires.
- COMMIT write:
  - All ACTIVE <= SHADOW on that edge.
  - pending <= 0.
  - commit_cnt increments, wrapping 255 -> 0.
  - commit_pulse = 1 for exactly the following cycle.
  - A commit with pending=0 still counts and pulses.
- Reads: fixed latency 1. s0_read sampled at edge k gives s0_readdata/s0_readdatavalid valid during cycle k+1. s0_readdata holds its value otherwise; s0_readdatavalid is low otherwise.
- Read and write in the same cycle: both are served. The read returns the pre-write value.
- No waitrequest: the slave accepts every transfer, back-to-back.

Decomposition:
- Package avmm_regbank_pkg holds:
  - address constants ADDR_SHADOW_BASE, ADDR_CTRL, ADDR_COMMIT, ADDR_STATUS, ADDR_ACTIVE_BASE;
  - CTRL/STATUS bit index constants;
  - a typedef for the status word layout.
- Sub-module rst_pipe_n (parameter RST_STAGES) produces the internal active-low reset.

Test Plan:
- Reset release: rst_in=0 for 4 cycles, then 1 -> r_export all RESET_VAL; internal reset deasserts exactly 2 edges after rst_in is sampled high; a read of 0x42 returns 0.
- Shadow then commit:
  - Stimulus: write 0x00=0xDEADBEEF, then read 0x80.
  - Expected: read returns 0 and STATUS bit0=1.
  - Stimulus: write 0x41.
  - Expected: r_export[31:0]=0xDEADBEEF the next cycle, commit_pulse for one cycle, STATUS=0x0000_0100.
- Byte enables: shadow[1]=0x11223344; write 0x01 data 0xAABBCCDD be=4'b0101 -> shadow[1]=0x11BB33DD.
- Auto-commit: write CTRL=1, then write 0x02=0x5 -> r_export ch2=0x5 the next cycle, commit_pulse stays 0, pending stays 0.
- Read/write collision and latency: write and read on 0x03 in the same cycle with old value 0x7 and new 0x9 -> readdatavalid is high 1 cycle later with data 0x7; the next read returns 0x9.
- Counter wrap and mid-read reset:
  - 256 COMMIT writes -> commit_cnt=0.
  - Assert a read, then drop rst_in -> readdatavalid and readdata both forced to 0 once the internal reset takes effect.
